// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 2-FF synchroniser, false-start
// rejection, parity/framing/overrun status and a valid/ready output handshake.
//
// Parameters: DATA_BITS (5..9, LSB first), CLKS_PER_BIT (even, >= 4),
//             PARITY_MODE (0 none, 1 even, 2 odd), STOP_BITS (1 or 2).
// Optional build macro: UART_RX_MAJORITY_EN -- each bit decision becomes the
//   2-of-3 majority of rx_s at centre-1, centre, centre+1 (same latency).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_en      receiver enable; low forces IDLE and clears overrun
//   rx_data    asynchronous serial line, idle high
//   rx_ready   consumer accepts the current word
//   received   last received payload
//   rx_valid   received holds an unconsumed word
//   done       one-cycle pulse per completed frame
//   busy       frame in progress
//   parity_err parity mismatch on last frame
//   frame_err  a stop bit sampled low on last frame
//   overrun    frame completed while a word was still pending (sticky)
module uart_rx_param #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx_data,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] received,
    output logic                 rx_valid,
    output logic                 done,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_pend, par_pend_n;
    logic                 frm_pend, frm_pend_n;
    logic [DATA_BITS-1:0] received_n;
    logic                 rx_valid_n, done_n, busy_n;
    logic                 parity_err_n, frame_err_n, overrun_n;
    logic                 rx_m, rx_s, rx_d1;
    logic                 bit_s;
    logic                 parity_calc;
    logic                 complete;

    // Bit decision; rx_m is one cycle ahead of rx_s, rx_d1 one cycle behind.
`ifdef UART_RX_MAJORITY_EN
    assign bit_s = (rx_d1 & rx_s) | (rx_d1 & rx_m) | (rx_s & rx_m);
`else
    assign bit_s = rx_s;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt + CNT_W'(1);
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        par_pend_n   = par_pend;
        frm_pend_n   = frm_pend;
        received_n   = received;
        rx_valid_n   = rx_valid;
        done_n       = 1'b0;
        parity_err_n = parity_err;
        frame_err_n  = frame_err;
        overrun_n    = overrun;
        complete     = 1'b0;
        parity_calc  = (^shreg) ^ (PARITY_MODE == 2);

        if (rx_valid && rx_ready) begin
            rx_valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_en && rx_d1 && !rx_s) begin
                    state_n    = START;
                    bit_cnt_n  = '0;
                    par_pend_n = 1'b0;
                    frm_pend_n = 1'b0;
                end
            end
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    // A line back high at the start-bit centre is a glitch.
                    state_n   = bit_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_END) begin
                    cnt_n     = '0;
                    shreg_n   = {bit_s, shreg[DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_MODE != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt == CNT_END) begin
                    cnt_n      = '0;
                    par_pend_n = (bit_s != parity_calc);
                    state_n    = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_END) begin
                    cnt_n     = '0;
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                    if (!bit_s) begin
                        frm_pend_n = 1'b1;
                    end
                    if (bit_cnt == STOP_LAST) begin
                        complete = 1'b1;
                        state_n  = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (!rx_en) begin
            // Abort: drop the frame, keep the last word and its flags.
            state_n   = IDLE;
            cnt_n     = '0;
            overrun_n = 1'b0;
        end else if (complete) begin
            received_n   = shreg;
            parity_err_n = par_pend;
            frame_err_n  = frm_pend | !bit_s;
            done_n       = 1'b1;
            if (rx_valid && !rx_ready) begin
                overrun_n = 1'b1;
            end
            rx_valid_n = 1'b1;
        end

        busy_n = (state_n != IDLE);
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_pend   <= 1'b0;
            frm_pend   <= 1'b0;
            received   <= '0;
            rx_valid   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_d1      <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par_pend   <= par_pend_n;
            frm_pend   <= frm_pend_n;
            received   <= received_n;
            rx_valid   <= rx_valid_n;
            done       <= done_n;
            busy       <= busy_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
            overrun    <= overrun_n;
            rx_m       <= rx_data;
            rx_s       <= rx_m;
            rx_d1      <= rx_s;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: four receiver configurations (8N1, 8E1, 8O2, 5O1) driven
// by a frame-level line driver; a frame-level model predicts every output on
// every cycle, plus literal expectations for the directed frames.
module tb_uart_rx_param;

    localparam int CPB = 16;

    typedef struct packed {
        int         start;
        int         end_c;
        logic       has_done;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } rec_t;

    logic       clk;
    logic       rst;
    logic [3:0] rx_data_v, en_v, ready_v;
    logic [3:0] valid_v, done_v, busy_v, perr_v, ferr_v, ovr_v;
    logic [7:0] recv0, recv1, recv2;
    logic [4:0] recv3;

    rec_t       recs [4][64];
    int         hd [4];
    int         tl [4];
    logic [8:0] m_recv [4];
    logic       m_valid [4];
    logic       m_done [4];
    logic       m_busy [4];
    logic       m_perr [4];
    logic       m_ferr [4];
    logic       m_ovr [4];
    int         last_k [4];
    int         last_done [4];
    int         done_cnt [4];
    int         cyc;
    int         errors;
    int         checks;
    bit         chk_on;
    int         fin;

    uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .rx_en(en_v[0]), .rx_data(rx_data_v[0]), .rx_ready(ready_v[0]),
        .received(recv0), .rx_valid(valid_v[0]), .done(done_v[0]), .busy(busy_v[0]),
        .parity_err(perr_v[0]), .frame_err(ferr_v[0]), .overrun(ovr_v[0]));
    uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .rx_en(en_v[1]), .rx_data(rx_data_v[1]), .rx_ready(ready_v[1]),
        .received(recv1), .rx_valid(valid_v[1]), .done(done_v[1]), .busy(busy_v[1]),
        .parity_err(perr_v[1]), .frame_err(ferr_v[1]), .overrun(ovr_v[1]));
    uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2)) u_8o2 (
        .clk(clk), .rst(rst), .rx_en(en_v[2]), .rx_data(rx_data_v[2]), .rx_ready(ready_v[2]),
        .received(recv2), .rx_valid(valid_v[2]), .done(done_v[2]), .busy(busy_v[2]),
        .parity_err(perr_v[2]), .frame_err(ferr_v[2]), .overrun(ovr_v[2]));
    uart_rx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1)) u_5o1 (
        .clk(clk), .rst(rst), .rx_en(en_v[3]), .rx_data(rx_data_v[3]), .rx_ready(ready_v[3]),
        .received(recv3), .rx_valid(valid_v[3]), .done(done_v[3]), .busy(busy_v[3]),
        .parity_err(perr_v[3]), .frame_err(ferr_v[3]), .overrun(ovr_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int db(input int i);
        return (i == 3) ? 5 : 8;
    endfunction

    function automatic int pm(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 2);
    endfunction

    function automatic int sb(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] recv_of(input int i);
        case (i)
            0:       return {1'b0, recv0};
            1:       return {1'b0, recv1};
            2:       return {1'b0, recv2};
            default: return {4'b0, recv3};
        endcase
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input rec_t r);
        recs[i][tl[i]] = r;
        tl[i] = (tl[i] + 1) % 64;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            hd[i] = 0; tl[i] = 0;
            m_recv[i] = '0; m_valid[i] = 0; m_done[i] = 0; m_busy[i] = 0;
            m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0;
        end
    endtask

    // Frame-level model: a frame whose falling edge is driven in cycle k has
    // its edge on rx_s at t0 = k+2, is busy from t0+1 and completes (done)
    // at t0 + CPB/2 + nbits*CPB + 1.
    always @(posedge clk) begin
        logic comp;
        cyc = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            comp = 1'b0;
            if (hd[i] != tl[i] && recs[i][hd[i]].end_c == cyc) begin
                comp = recs[i][hd[i]].has_done;
                if (comp) begin
                    if (m_valid[i] && !ready_v[i]) m_ovr[i] = 1'b1;
                    m_valid[i] = 1'b1;
                    m_recv[i]  = recs[i][hd[i]].data;
                    m_perr[i]  = recs[i][hd[i]].perr;
                    m_ferr[i]  = recs[i][hd[i]].ferr;
                end
                hd[i] = (hd[i] + 1) % 64;
            end
            if (!comp && m_valid[i] && ready_v[i]) m_valid[i] = 1'b0;
            if (!en_v[i]) m_ovr[i] = 1'b0;
            m_done[i] = comp;
            m_busy[i] = (hd[i] != tl[i]) && (recs[i][hd[i]].start <= cyc) && (cyc < recs[i][hd[i]].end_c);
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_v[i] === 1'b1) begin
                last_done[i] = cyc;
                done_cnt[i]  = done_cnt[i] + 1;
            end
            if (chk_on) begin
                chk("done", i, 32'(done_v[i]), 32'(m_done[i]));
                chk("busy", i, 32'(busy_v[i]), 32'(m_busy[i]));
                chk("rx_valid", i, 32'(valid_v[i]), 32'(m_valid[i]));
                chk("received", i, 32'(recv_of(i)), 32'(m_recv[i]));
                chk("parity_err", i, 32'(perr_v[i]), 32'(m_perr[i]));
                chk("frame_err", i, 32'(ferr_v[i]), 32'(m_ferr[i]));
                chk("overrun", i, 32'(ovr_v[i]), 32'(m_ovr[i]));
            end
        end
    end

    // Drive one frame; bad_par flips the parity bit, stops gives the stop
    // bit values (bit 0 first), abort_bit >= 0 drops rx_en mid data bit.
    task automatic send_frame(input int i, input logic [8:0] d, input bit bad_par,
                              input logic [1:0] stops, input int abort_bit);
        int         n;
        int         k;
        int         j;
        int         idx;
        logic [8:0] dm;
        logic       pbit;
        logic       bits [0:12];
        rec_t       r;
        n    = db(i) + ((pm(i) != 0) ? 1 : 0) + sb(i);
        dm   = d & 9'((1 << db(i)) - 1);
        pbit = (^dm) ^ (pm(i) == 2) ^ bad_par;
        bits[0] = 1'b0;
        for (int b = 0; b < db(i); b++) bits[1 + b] = dm[b];
        idx = 1 + db(i);
        if (pm(i) != 0) begin
            bits[idx] = pbit;
            idx++;
        end
        bits[idx] = stops[0];
        if (sb(i) == 2) bits[idx + 1] = stops[1];
        k = cyc;
        last_k[i] = k;
        j = k + CPB * (abort_bit + 1) + CPB / 2;
        r.start    = k + 3;
        r.has_done = (abort_bit < 0);
        r.end_c    = (abort_bit < 0) ? (k + 2 + CPB / 2 + n * CPB + 1) : (j + 1);
        r.data     = dm;
        r.perr     = (pm(i) != 0) && bad_par;
        r.ferr     = !stops[0] || (sb(i) == 2 && !stops[1]);
        push(i, r);
        for (int t = 0; t < CPB * (n + 1); t++) begin
            if (abort_bit >= 0 && t == CPB * (abort_bit + 1) + CPB / 2) begin
                en_v[i]      = 1'b0;
                rx_data_v[i] = 1'b1;
                repeat (4) tick();
                en_v[i] = 1'b1;
                return;
            end
            rx_data_v[i] = bits[t / CPB];
            tick();
        end
        rx_data_v[i] = 1'b1;
    endtask

    // Short low pulse: rejected at the start-bit centre (t0 + CPB/2).
    task automatic glitch(input int i, input int len);
        rec_t r;
        r.start    = cyc + 3;
        r.end_c    = cyc + 2 + CPB / 2 + 1;
        r.has_done = 1'b0;
        r.data     = '0;
        r.perr     = 1'b0;
        r.ferr     = 1'b0;
        push(i, r);
        rx_data_v[i] = 1'b0;
        repeat (len) tick();
        rx_data_v[i] = 1'b1;
        repeat (12 - len) tick();
    endtask

    task automatic rand_run(input int i, input int nframes);
        logic [1:0] st;
        for (int f = 0; f < nframes; f++) begin
            repeat ($urandom_range(1, 12)) tick();
            if ($urandom_range(0, 7) == 0) begin
                glitch(i, $urandom_range(1, 6));
            end else begin
                st[0] = ($urandom_range(0, 4) != 0);
                st[1] = ($urandom_range(0, 4) != 0);
                send_frame(i, 9'($urandom), ($urandom_range(0, 3) == 0), st, -1);
            end
        end
        fin++;
    endtask

    initial begin
        int dc;
        rst = 1'b0;
        rx_data_v = 4'hF;
        en_v = 4'hF;
        ready_v = 4'h0;
        cyc = 0; errors = 0; checks = 0; chk_on = 1'b0; fin = 0;
        for (int i = 0; i < 4; i++) begin
            last_k[i] = 0; last_done[i] = 0; done_cnt[i] = 0;
        end
        clear_model();

        // Reset state.
        #2;
        for (int i = 0; i < 4; i++) begin
            chk("rst_received", i, 32'(recv_of(i)), 32'h0);
            chk("rst_valid", i, 32'(valid_v[i]), 32'h0);
            chk("rst_busy", i, 32'(busy_v[i]), 32'h0);
            chk("rst_done", i, 32'(done_v[i]), 32'h0);
        end
        tick(); tick();
        rst = 1'b1;
        chk_on = 1'b1;
        repeat (4) tick();

        // 8N1: 0xA5, done at t0+153, then accept.
        send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);
        repeat (4) tick();
        chk("lit_8n1_latency", 0, 32'(last_done[0] - (last_k[0] + 2)), 32'd153);
        chk("lit_8n1_received", 0, 32'(recv0), 32'hA5);
        chk("lit_8n1_valid", 0, 32'(valid_v[0]), 32'h1);
        chk("lit_8n1_errs", 0, {30'b0, perr_v[0], ferr_v[0]}, 32'h0);
        ready_v[0] = 1'b1;
        tick();
        chk("lit_8n1_accept", 0, 32'(valid_v[0]), 32'h0);
        ready_v[0] = 1'b0;

        // 8E1: 0xA5 with parity bit 1 (wrong), then 0x01 with parity bit 1 (right).
        send_frame(1, 9'h0A5, 1'b1, 2'b11, -1);
        repeat (4) tick();
        chk("lit_8e1_received", 1, 32'(recv1), 32'hA5);
        chk("lit_8e1_perr", 1, 32'(perr_v[1]), 32'h1);
        chk("lit_8e1_ferr", 1, 32'(ferr_v[1]), 32'h0);
        send_frame(1, 9'h001, 1'b0, 2'b11, -1);
        repeat (4) tick();
        chk("lit_8e1_perr_ok", 1, 32'(perr_v[1]), 32'h0);

        // 8O2: second stop bit low, done at t0+185; then a 5-cycle glitch.
        send_frame(2, 9'h03C, 1'b0, 2'b01, -1);
        repeat (4) tick();
        chk("lit_8o2_latency", 2, 32'(last_done[2] - (last_k[2] + 2)), 32'd185);
        chk("lit_8o2_ferr", 2, 32'(ferr_v[2]), 32'h1);
        chk("lit_8o2_received", 2, 32'(recv2), 32'h3C);
        dc = done_cnt[2];
        glitch(2, 5);
        chk("lit_glitch_busy", 2, 32'(busy_v[2]), 32'h0);
        chk("lit_glitch_nodone", 2, 32'(done_cnt[2] - dc), 32'h0);

        // Overrun, then rx_en low clears it and keeps the word.
        send_frame(0, 9'h011, 1'b0, 2'b11, -1);
        send_frame(0, 9'h022, 1'b0, 2'b11, -1);
        repeat (2) tick();
        chk("lit_ovr_received", 0, 32'(recv0), 32'h22);
        chk("lit_ovr_set", 0, 32'(ovr_v[0]), 32'h1);
        en_v[0] = 1'b0;
        tick();
        chk("lit_ovr_clear", 0, 32'(ovr_v[0]), 32'h0);
        chk("lit_ovr_keep", 0, 32'(recv0), 32'h22);
        en_v[0] = 1'b1;
        repeat (3) tick();

        // Abort during data bit 3.
        dc = done_cnt[0];
        send_frame(0, 9'h05A, 1'b0, 2'b11, 3);
        repeat (2) tick();
        chk("lit_abort_busy", 0, 32'(busy_v[0]), 32'h0);
        chk("lit_abort_nodone", 0, 32'(done_cnt[0] - dc), 32'h0);
        chk("lit_abort_keep", 0, 32'(recv0), 32'h22);

        // 5O1: 0x15 (three ones) with parity bit 0 is correct.
        send_frame(3, 9'h015, 1'b0, 2'b11, -1);
        repeat (4) tick();
        chk("lit_5o1_received", 3, 32'(recv3), 32'h15);
        chk("lit_5o1_errs", 3, {30'b0, perr_v[3], ferr_v[3]}, 32'h0);

        // Randomised frames on all four receivers with random rx_ready.
        fork
            rand_run(0, 15);
            rand_run(1, 15);
            rand_run(2, 15);
            rand_run(3, 15);
            begin
                while (fin < 4) begin
                    tick();
                    ready_v = 4'($urandom);
                end
            end
        join
        ready_v = 4'h0;
        repeat (20) tick();

        // Asynchronous reset mid-frame.
        chk_on = 1'b0;
        rx_data_v[0] = 1'b0;
        repeat (40) tick();
        chk("lit_pre_rst_busy", 0, 32'(busy_v[0]), 32'h1);
        #3;
        rst = 1'b0;
        #1;
        chk("lit_arst_received", 0, 32'(recv0), 32'h0);
        chk("lit_arst_busy", 0, 32'(busy_v[0]), 32'h0);
        chk("lit_arst_flags", 0, {26'b0, valid_v[0], done_v[0], perr_v[0], ferr_v[0], ovr_v[0], busy_v[0]}, 32'h0);
        rx_data_v = 4'hF;
        clear_model();
        tick();
        rst = 1'b1;
        chk_on = 1'b1;
        repeat (3) tick();
        send_frame(0, 9'h096, 1'b0, 2'b11, -1);
        repeat (6) tick();
        chk("lit_post_rst_received", 0, 32'(recv0), 32'h96);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
